meter_cmd_sched: RTL and testbench
==================================

METER_CMD_SCHED -- requirements
Module: meter_cmd_sched

Interface
REQ-001 SHALL have parameter MAX_TIME, default 9999, the saturation ceiling for the meter time in seconds.
REQ-002 SHALL have parameter LOW_THRESH, default 200, below which a nonzero time is reported as low.
REQ-003 SHALL have port Decr_Clk, input, 1 bit: block clock, all state updates on its rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port coin_pulse, input, 4 bits: single-cycle coin events; [0]=+10, [1]=+180, [2]=+200, [3]=+550.
REQ-006 SHALL have ports sw0 and sw1, input, 1 bit each: level switches; sw0 loads 10, sw1 loads 205.
REQ-007 SHALL have port sec_tick, input, 1 bit: single-cycle one-second decrement request.
REQ-008 SHALL have port cur_time, input, 16 bits: current time fed back from the counter datapath.
REQ-009 SHALL have port cmd_ready, input, 1 bit: the datapath accepts the command this cycle.
REQ-010 SHALL have port cmd_valid, output, 1 bit: a command is presented.
REQ-011 SHALL have port cmd_op, output, 2 bits: 0 ADD, 1 LOAD, 2 DEC.
REQ-012 SHALL have port cmd_data, output, 16 bits: the operand for ADD/LOAD; 0 for DEC.
REQ-013 SHALL have ports expired and low_time, output, 1 bit each: expired = (cur_time==0); low_time = (0<cur_time<LOW_THRESH).
REQ-014 SHALL have port tick_ovf, output, 1 bit: sticky flag, set when a sec_tick arrives while a tick is already pending.

Function
REQ-015 SHALL capture each coin_pulse bit and each rising edge of sw0/sw1 into its own sticky pending bit on the edge that samples it; repeat events on an already-pending source SHALL merge.
REQ-016 SHALL run a two-state FSM, IDLE and ISSUE; IDLE->ISSUE when any request is pending; ISSUE->IDLE on valid&&ready with nothing else pending, otherwise stay in ISSUE with the next command.
REQ-017 SHALL use fixed arbitration priority: sw0 load > sw1 load > coin[0] > coin[1] > coin[2] > coin[3] > tick.
REQ-018 SHALL register cmd_valid, cmd_op and cmd_data; the earliest cmd_valid SHALL occur one edge after the capture edge, and the outputs SHALL stay stable while cmd_valid && !cmd_ready.
REQ-019 SHALL clear the serviced pending bit on the retire edge; a new event on that same source at that edge SHALL leave the bit set.
REQ-020 SHALL allow back-to-back commands: the next command is presented on the retire edge without a bubble.
REQ-021 SHALL set a hold flag when a switch load retires and either switch is still high; it SHALL clear when both switches are low.
REQ-022 SHALL discard sec_tick without pending it while hold is set; coins SHALL still be serviced during hold.
REQ-023 SHALL drop a pending tick without issuing a command when cur_time==0 at arbitration, so no DEC below zero is issued.
REQ-024 SHALL OR simultaneous sw0 and sw1 rising edges into pending, with sw0 served first and sw1 following.

Reset
REQ-025 SHALL, while RESET is high, immediately force cmd_valid=0, cmd_op=0, cmd_data=0, tick_ovf=0, all pending bits 0, hold=0 and FSM=IDLE, including in the middle of a handshake.
REQ-026 SHALL treat switches already high at reset release as not being rising edges.

Configuration
REQ-027 SHALL, with METER_SAT_EN defined, issue LOAD MAX_TIME instead of ADD when cur_time + amount > MAX_TIME, computed at 17-bit width.
REQ-028 SHALL, without METER_SAT_EN, always issue ADD with the raw amount; the datapath wraps modulo 2^16.

Structure
REQ-029 SHALL take the op encodings, the coin amounts (10/180/200/550), the switch load values (10/205) and MAX_TIME from package meter_pkg.
REQ-030 SHALL implement capture and edge detection in one sub-module, meter_req_latch, instantiated once.

Verification
REQ-031 SHALL cover: coin[1] pulse, cur_time=100, ready=1 -> one ADD 180, valid for exactly one cycle, two edges after the pulse.
REQ-032 SHALL cover: coin[0] and coin[3] in the same cycle, ready held low 3 cycles -> ADD 10 held stable, then ADD 550 back-to-back.
REQ-033 SHALL cover: sw1 raised and held, sec_tick every 4 cycles -> LOAD 205 and no DEC until sw1 falls, then DEC resumes.
REQ-034 SHALL cover: METER_SAT_EN defined, cur_time=9900, coin[3] -> LOAD 9999; without the macro -> ADD 550.
REQ-035 SHALL cover: cur_time=0 with sec_tick -> no command and expired=1; two ticks while ready=0 -> tick_ovf=1.
REQ-036 SHALL cover: RESET asserted while cmd_valid=1 && !ready -> all outputs 0 with no clock edge, and no command after release.

Source files
------------

// File: rtl/meter_pkg.sv
// Shared encodings and constants for the meter command scheduler and its request latch.
package meter_pkg;

   localparam int unsigned MaxTime = 9999;
   localparam int unsigned NumSrc  = 7;

   typedef enum logic [1:0] {
      OpAdd  = 2'd0,
      OpLoad = 2'd1,
      OpDec  = 2'd2
   } cmd_op_e;

   // Source index doubles as arbitration rank: the lowest pending index wins.
   typedef enum logic [2:0] {
      SrcSw0   = 3'd0,
      SrcSw1   = 3'd1,
      SrcCoin0 = 3'd2,
      SrcCoin1 = 3'd3,
      SrcCoin2 = 3'd4,
      SrcCoin3 = 3'd5,
      SrcTick  = 3'd6
   } src_e;

   localparam logic [15:0] Coin0Amt = 16'd10;
   localparam logic [15:0] Coin1Amt = 16'd180;
   localparam logic [15:0] Coin2Amt = 16'd200;
   localparam logic [15:0] Coin3Amt = 16'd550;
   localparam logic [15:0] Sw0Load  = 16'd10;
   localparam logic [15:0] Sw1Load  = 16'd205;

   function automatic logic [15:0] src_amount(src_e src);
      case (src)
         SrcSw0:   return Sw0Load;
         SrcSw1:   return Sw1Load;
         SrcCoin0: return Coin0Amt;
         SrcCoin1: return Coin1Amt;
         SrcCoin2: return Coin2Amt;
         SrcCoin3: return Coin3Amt;
         default:  return 16'd0;
      endcase
   endfunction

   function automatic cmd_op_e src_op(src_e src);
      case (src)
         SrcSw0, SrcSw1: return OpLoad;
         SrcTick:        return OpDec;
         default:        return OpAdd;
      endcase
   endfunction

endpackage

// File: rtl/meter_req_latch.sv
// Sticky request capture: coin pulses, switch rising edges and second ticks become pending bits
// that stay set until the scheduler clears them.
module meter_req_latch
   import meter_pkg::*;
(
   input  logic              Decr_Clk,
   input  logic              RESET,
   input  logic [3:0]        coin_pulse,
   input  logic              sw0,
   input  logic              sw1,
   input  logic              sec_tick,
   input  logic              hold,
   input  logic [NumSrc-1:0] clr,
   output logic [NumSrc-1:0] pend,
   output logic              tick_ovf
);

   logic              sw0_q, sw1_q;
   logic [NumSrc-1:0] pend_q, pend_d, set;
   logic              tick_ovf_q, tick_ovf_d;

   always_comb begin
      set        = {sec_tick & ~hold, coin_pulse, sw1 & ~sw1_q, sw0 & ~sw0_q};
      // A new event on a source being cleared this edge wins, so nothing is lost.
      pend_d     = (pend_q & ~clr) | set;
      tick_ovf_d = tick_ovf_q | (sec_tick & pend_q[SrcTick] & ~clr[SrcTick]);
   end

   // Switch history resets high so a switch already up at release is not an edge.
   always_ff @(posedge Decr_Clk or posedge RESET) begin
      if (RESET) begin
         sw0_q      <= 1'b1;
         sw1_q      <= 1'b1;
         pend_q     <= '0;
         tick_ovf_q <= 1'b0;
      end else begin
         sw0_q      <= sw0;
         sw1_q      <= sw1;
         pend_q     <= pend_d;
         tick_ovf_q <= tick_ovf_d;
      end
   end

   assign pend     = pend_q;
   assign tick_ovf = tick_ovf_q;

endmodule

// File: rtl/meter_cmd_sched.sv
// Meter command scheduler: arbitrates pending coin/switch/tick requests into a valid/ready
// command stream. Define METER_SAT_EN to turn over-ceiling ADDs into LOAD MAX_TIME.
module meter_cmd_sched
   import meter_pkg::*;
#(
   parameter int unsigned MAX_TIME   = MaxTime,
   parameter int unsigned LOW_THRESH = 200
) (
   input  logic        Decr_Clk,
   input  logic        RESET,
   input  logic [3:0]  coin_pulse,
   input  logic        sw0,
   input  logic        sw1,
   input  logic        sec_tick,
   input  logic [15:0] cur_time,
   input  logic        cmd_ready,
   output logic        cmd_valid,
   output logic [1:0]  cmd_op,
   output logic [15:0] cmd_data,
   output logic        expired,
   output logic        low_time,
   output logic        tick_ovf
);

   typedef enum logic {StIdle, StIssue} state_e;

   state_e            state_q, state_d;
   src_e              src_q, src_d, pick;
   cmd_op_e           op_q, op_d;
   logic [15:0]       data_q, data_d;
   logic              valid_q, valid_d;
   logic              hold_q, hold_d;
   logic [NumSrc-1:0] pend, clr, avail;
   logic              retire, found, arb, sat_en;
   logic [16:0]       sum;

`ifdef METER_SAT_EN
   assign sat_en = 1'b1;
`else
   assign sat_en = 1'b0;
`endif

   meter_req_latch u_req_latch (
      .Decr_Clk   (Decr_Clk),
      .RESET      (RESET),
      .coin_pulse (coin_pulse),
      .sw0        (sw0),
      .sw1        (sw1),
      .sec_tick   (sec_tick),
      .hold       (hold_q),
      .clr        (clr),
      .pend       (pend),
      .tick_ovf   (tick_ovf)
   );

   assign retire = valid_q & cmd_ready;

   // The source retiring this edge is excluded so the next command follows without a bubble.
   always_comb begin
      avail = pend;
      if (retire) avail[src_q] = 1'b0;
      found = 1'b0;
      pick  = SrcSw0;
      for (int i = int'(NumSrc) - 1; i >= 0; i--) begin
         if (avail[i]) begin
            found = 1'b1;
            pick  = src_e'(3'(i));
         end
      end
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      op_d    = op_q;
      data_d  = data_q;
      valid_d = valid_q;
      clr     = '0;
      sum     = {1'b0, cur_time} + {1'b0, src_amount(pick)};
      arb     = 1'b0;

      if (retire) clr[src_q] = 1'b1;

      case (state_q)
         StIdle:  arb = 1'b1;
         StIssue: arb = retire;
         default: arb = 1'b1;
      endcase

      if (arb) begin
         state_d = StIdle;
         valid_d = 1'b0;
         op_d    = OpAdd;
         data_d  = '0;
         if (found) begin
            if (pick == SrcTick && cur_time == '0) begin
               clr[SrcTick] = 1'b1;
            end else begin
               state_d = StIssue;
               valid_d = 1'b1;
               src_d   = pick;
               op_d    = src_op(pick);
               data_d  = src_amount(pick);
               if (sat_en && op_d == OpAdd && sum > 17'(MAX_TIME)) begin
                  op_d   = OpLoad;
                  data_d = 16'(MAX_TIME);
               end
            end
         end
      end

      hold_d = hold_q;
      if (!sw0 && !sw1) begin
         hold_d = 1'b0;
      end else if (retire && (src_q == SrcSw0 || src_q == SrcSw1)) begin
         hold_d = 1'b1;
      end
   end

   always_ff @(posedge Decr_Clk or posedge RESET) begin
      if (RESET) begin
         state_q <= StIdle;
         src_q   <= SrcSw0;
         op_q    <= OpAdd;
         data_q  <= '0;
         valid_q <= 1'b0;
         hold_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         op_q    <= op_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         hold_q  <= hold_d;
      end
   end

   assign cmd_valid = valid_q;
   assign cmd_op    = op_q;
   assign cmd_data  = data_q;
   assign expired   = (cur_time == '0);
   assign low_time  = (cur_time != '0) && (32'(cur_time) < LOW_THRESH);

endmodule

// File: tb/tb_meter_cmd_sched.sv
// Bench for meter_cmd_sched: directed scenarios then random traffic, all checked against a
// request-set reference model with a simple time datapath.
module tb_meter_cmd_sched;

   logic        Decr_Clk = 1'b0;
   logic        RESET;
   logic [3:0]  coin_pulse;
   logic        sw0, sw1, sec_tick, cmd_ready;
   logic [15:0] cur_time;
   logic        cmd_valid, expired, low_time, tick_ovf;
   logic [1:0]  cmd_op;
   logic [15:0] cmd_data;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state: pending request set, presented command, hold and overflow flags.
   logic [6:0] m_pend;
   bit         m_valid, m_hold, m_ovf, m_sw0p, m_sw1p;
   int         m_op, m_data, m_src;
   bit         use_dp;
   int         amt [7] = '{10, 205, 10, 180, 200, 550, 0};
   int         ops [7] = '{1, 1, 0, 0, 0, 0, 2};

   meter_cmd_sched dut (
      .Decr_Clk   (Decr_Clk),
      .RESET      (RESET),
      .coin_pulse (coin_pulse),
      .sw0        (sw0),
      .sw1        (sw1),
      .sec_tick   (sec_tick),
      .cur_time   (cur_time),
      .cmd_ready  (cmd_ready),
      .cmd_valid  (cmd_valid),
      .cmd_op     (cmd_op),
      .cmd_data   (cmd_data),
      .expired    (expired),
      .low_time   (low_time),
      .tick_ovf   (tick_ovf)
   );

   always #5 Decr_Clk = ~Decr_Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pend  = '0;
      m_valid = 0;
      m_hold  = 0;
      m_ovf   = 0;
      m_sw0p  = 1;
      m_sw1p  = 1;
      m_op    = 0;
      m_data  = 0;
      m_src   = 0;
   endtask

   // Advance the model by one clock edge using the inputs now applied; nt is the datapath time.
   task automatic model_edge(output int nt);
      logic [6:0] nxt;
      bit retire, clr6;
      int pick, old_src, old_op, old_data;
      retire   = m_valid && cmd_ready;
      old_src  = m_src;
      old_op   = m_op;
      old_data = m_data;
      nxt      = m_pend;
      clr6     = 0;
      if (retire) begin
         nxt[m_src] = 1'b0;
         if (m_src == 6) clr6 = 1;
      end
      if (!m_valid || retire) begin
         pick = -1;
         for (int i = 0; i < 7; i++) if (nxt[i] && pick < 0) pick = i;
         m_valid = 0;
         m_op    = 0;
         m_data  = 0;
         if (pick == 6 && cur_time == 0) begin
            nxt[6] = 1'b0;
            clr6   = 1;
         end else if (pick >= 0) begin
            m_valid = 1;
            m_src   = pick;
            m_op    = ops[pick];
            m_data  = amt[pick];
`ifdef METER_SAT_EN
            if (m_op == 0 && int'(cur_time) + amt[pick] > 9999) begin
               m_op   = 1;
               m_data = 9999;
            end
`endif
         end
      end
      if (sec_tick && m_pend[6] && !clr6) m_ovf = 1;
      if (sw0 && !m_sw0p) nxt[0] = 1'b1;
      if (sw1 && !m_sw1p) nxt[1] = 1'b1;
      for (int i = 0; i < 4; i++) if (coin_pulse[i]) nxt[i + 2] = 1'b1;
      if (sec_tick && !m_hold) nxt[6] = 1'b1;
      if (!sw0 && !sw1) m_hold = 0;
      else if (retire && old_src < 2) m_hold = 1;
      m_sw0p = sw0;
      m_sw1p = sw1;
      m_pend = nxt;
      nt = int'(cur_time);
      if (retire) begin
         if (old_op == 0) nt = (nt + old_data) & 16'hffff;
         else if (old_op == 1) nt = old_data;
         else nt = (nt - 1) & 16'hffff;
      end
   endtask

   task automatic check_all();
      chk("cmd_valid", 32'(cmd_valid), 32'(m_valid));
      chk("cmd_op", 32'(cmd_op), 32'(m_op));
      chk("cmd_data", 32'(cmd_data), 32'(m_data));
      chk("tick_ovf", 32'(tick_ovf), 32'(m_ovf));
      chk("expired", 32'(expired), 32'(cur_time == 0));
      chk("low_time", 32'(low_time), 32'(cur_time != 0 && cur_time < 200));
   endtask

   task automatic cyc();
      int nt;
      model_edge(nt);
      @(posedge Decr_Clk);
      #1;
      if (use_dp) cur_time = 16'(nt);
      #1;
      check_all();
   endtask

   initial begin
      RESET      = 1'b1;
      coin_pulse = '0;
      sw0        = 1'b0;
      sw1        = 1'b0;
      sec_tick   = 1'b0;
      cmd_ready  = 1'b1;
      cur_time   = 16'd100;
      use_dp     = 0;
      model_reset();
      #12;
      chk("rst_valid", 32'(cmd_valid), 0);
      chk("rst_op", 32'(cmd_op), 0);
      chk("rst_data", 32'(cmd_data), 0);
      chk("rst_ovf", 32'(tick_ovf), 0);
      RESET = 1'b0;
      cyc();

      // Single coin[1]: ADD 180 valid exactly one cycle, two edges after the pulse.
      coin_pulse = 4'b0010;
      cyc();
      coin_pulse = '0;
      cyc();
      chk("c1_valid", 32'(cmd_valid), 1);
      chk("c1_data", 32'(cmd_data), 180);
      cyc();
      chk("c1_once", 32'(cmd_valid), 0);

      // coin[0] and coin[3] together with ready low: ADD 10 held, then ADD 550 back-to-back.
      cmd_ready  = 1'b0;
      coin_pulse = 4'b1001;
      cyc();
      coin_pulse = '0;
      for (int i = 0; i < 3; i++) cyc();
      chk("hold_data", 32'(cmd_data), 10);
      cmd_ready = 1'b1;
      cyc();
      chk("b2b_valid", 32'(cmd_valid), 1);
      chk("b2b_data", 32'(cmd_data), 550);
      cyc();
      cyc();

      // sw1 held high with periodic ticks; ticks resume after sw1 falls.
      sw1 = 1'b1;
      for (int i = 0; i < 24; i++) begin
         sec_tick = (i % 4 == 3);
         cyc();
      end
      sw1 = 1'b0;
      for (int i = 0; i < 16; i++) begin
         sec_tick = (i % 4 == 1);
         cyc();
      end
      sec_tick = 1'b0;
      cyc();

      // Coin near the ceiling.
      cur_time   = 16'd9900;
      coin_pulse = 4'b1000;
      cyc();
      coin_pulse = '0;
      cyc();
`ifdef METER_SAT_EN
      chk("sat_op", 32'(cmd_op), 1);
      chk("sat_data", 32'(cmd_data), 9999);
`else
      chk("wrap_op", 32'(cmd_op), 0);
      chk("wrap_data", 32'(cmd_data), 550);
`endif
      cyc();

      // Tick at zero is dropped; two ticks against a stalled DEC overflow.
      cur_time = 16'd0;
      sec_tick = 1'b1;
      cyc();
      sec_tick = 1'b0;
      cyc();
      chk("zero_nocmd", 32'(cmd_valid), 0);
      chk("zero_exp", 32'(expired), 1);
      cur_time  = 16'd50;
      cmd_ready = 1'b0;
      sec_tick  = 1'b1;
      cyc();
      sec_tick = 1'b0;
      cyc();
      sec_tick = 1'b1;
      cyc();
      sec_tick = 1'b0;
      chk("ovf_set", 32'(tick_ovf), 1);
      cmd_ready = 1'b1;
      for (int i = 0; i < 3; i++) cyc();

      // Reset in the middle of a stalled handshake.
      cmd_ready  = 1'b0;
      coin_pulse = 4'b0100;
      cyc();
      coin_pulse = '0;
      cyc();
      chk("pre_rst_valid", 32'(cmd_valid), 1);
      RESET = 1'b1;
      #1;
      chk("arst_valid", 32'(cmd_valid), 0);
      chk("arst_op", 32'(cmd_op), 0);
      chk("arst_data", 32'(cmd_data), 0);
      chk("arst_ovf", 32'(tick_ovf), 0);
      model_reset();
      sw1 = 1'b1;
      @(posedge Decr_Clk);
      #1;
      RESET     = 1'b0;
      cmd_ready = 1'b1;
      for (int i = 0; i < 4; i++) cyc();
      chk("post_rst_idle", 32'(cmd_valid), 0);
      sw1 = 1'b0;
      cyc();

      // Random traffic with the time fed back from the modelled datapath.
      use_dp   = 1;
      cur_time = 16'd30;
      for (int i = 0; i < 500; i++) begin
         coin_pulse = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
         sec_tick   = ($urandom_range(0, 3) == 0);
         cmd_ready  = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 15) == 0) sw0 = ~sw0;
         if ($urandom_range(0, 15) == 0) sw1 = ~sw1;
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
